// File: rtl/xmit_pkg.sv
// Shared framing definitions for the xmit/rcvr pair: header pattern and
// the FSM phase encoding used by both ends of the serial link.
package xmit_pkg;

  localparam logic [7:0] MATCH_DEFAULT = 8'hA5;
  localparam logic [2:0] LAST_BIT      = 3'd7;

  // Phase plus a 3-bit bit counter encodes IDLE, HEAD1..HEAD8, BODY1..BODY8.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAD = 2'b01,
    ST_BODY = 2'b10
  } phase_t;

endpackage

// File: rtl/xmit.sv
// Serial framing transmitter: one-entry holding buffer feeding a 16-bit
// frame (8-bit MATCH header, then data MSB first), one bit per clock.
module xmit
  import xmit_pkg::*;
#(
  parameter logic [7:0] MATCH = MATCH_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       writing,
  output logic       ready,
  output logic       overrun,
  output logic       sending,
  output logic       data_out
);

  phase_t     phase, nxt_phase;
  logic [2:0] cnt, nxt_cnt;
  logic       nxt_out;
  logic       load, shift_en;
  logic       buf_full, accept;
  logic [7:0] hold_q, shift_q;

  assign ready   = ~buf_full;
  assign sending = (phase != ST_IDLE);
  assign accept  = writing & ~buf_full;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    nxt_phase = phase;
    nxt_cnt   = cnt;
    nxt_out   = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (phase)
      ST_IDLE: begin
        if (buf_full) begin
          load      = 1'b1;
          nxt_phase = ST_HEAD;
          nxt_cnt   = 3'd0;
          nxt_out   = MATCH[7];
        end
      end
      ST_HEAD: begin
        if (cnt == LAST_BIT) begin
          nxt_phase = ST_BODY;
          nxt_cnt   = 3'd0;
          nxt_out   = shift_q[7];
          shift_en  = 1'b1;
        end else begin
          nxt_cnt = cnt + 3'd1;
          nxt_out = MATCH[3'd6 - cnt];
        end
      end
      ST_BODY: begin
        if (cnt != LAST_BIT) begin
          nxt_cnt  = cnt + 3'd1;
          nxt_out  = shift_q[7];
          shift_en = 1'b1;
        end else if (buf_full) begin
          // Back-to-back: reload and start the next header with no idle bit.
          load      = 1'b1;
          nxt_phase = ST_HEAD;
          nxt_cnt   = 3'd0;
          nxt_out   = MATCH[7];
        end else begin
          nxt_phase = ST_IDLE;
          nxt_cnt   = 3'd0;
        end
      end
      default: begin
        nxt_phase = ST_IDLE;
        nxt_cnt   = 3'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase    <= ST_IDLE;
      cnt      <= 3'd0;
      data_out <= 1'b0;
      buf_full <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      phase    <= nxt_phase;
      cnt      <= nxt_cnt;
      data_out <= nxt_out;
      // accept and load are mutually exclusive: one needs the buffer empty,
      // the other full.
      if (accept)    buf_full <= 1'b1;
      else if (load) buf_full <= 1'b0;
      if (accept)       overrun <= 1'b0;
      else if (writing) overrun <= 1'b1;
    end
  end

  // NOTE: data registers carry no reset; their contents only matter once
  // buf_full/phase (which are reset) say they are valid.
  always_ff @(posedge clock) begin
    if (accept) hold_q <= data_in;
    if (load)          shift_q <= hold_q;
    else if (shift_en) shift_q <= {shift_q[6:0], 1'b0};
  end

endmodule
